write_data_dispatch: RTL and testbench

Write-direction counterpart of the controller's read-data return FIFO. The block buffers full-width frontend write-data words and, when the backend issues a write command, serializes one buffered word into `BEATS` backend-width beats on consecutive cycles. It sits between the frontend command/data interface and the backend DRAM write path. It reports full, empty and a watermark stall to the frontend.

---
 rtl/write_data_dispatch.sv | 216 +++++++++++++++++++++
 tb/tb_write_data_dispatch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/write_data_dispatch.sv
// write_data_dispatch
//
// Buffers full-width frontend write words in a small FIFO and, on each
// backend write command, serializes the oldest word into BEATS
// backend-width beats on consecutive cycles. The word is popped at the
// edge that ends its last beat.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_data       frontend write word, beat k = i_data[k*DATA_WIDTH +: DATA_WIDTH]
//   wr_en        push request (dropped while o_full)
//   o_full       registered, FIFO holds 2^FIFO_DEPTH words
//   o_empty      registered, FIFO holds no words
//   o_stall      registered, occupancy >= 2^STALL_WATERMARK
//   o_count      registered occupancy
//   i_burst_req  backend write command, requests one word
//   o_bk_data    registered beat data, held when o_bk_valid is low
//   o_bk_valid   registered beat valid
//   o_bk_last    registered, final beat of the burst
//   o_busy       registered, burst in progress
//   o_proto_err  sticky, burst request while empty or while busy

`ifndef BACKEND_WORD_SIZE
`define BACKEND_WORD_SIZE 64
`endif

module write_data_dispatch #(
  parameter int DATA_WIDTH      = `BACKEND_WORD_SIZE,
  parameter int BEATS           = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_WATERMARK = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [BEATS*DATA_WIDTH-1:0] i_data,
  input  logic                        wr_en,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_stall,
  output logic [FIFO_DEPTH:0]         o_count,
  input  logic                        i_burst_req,
  output logic [DATA_WIDTH-1:0]       o_bk_data,
  output logic                        o_bk_valid,
  output logic                        o_bk_last,
  output logic                        o_busy,
  output logic                        o_proto_err
);

  localparam int DEPTH  = 1 << FIFO_DEPTH;
  localparam int PTR_W  = FIFO_DEPTH + 1;
  localparam int WORD_W = BEATS * DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  STALL_COUNT = PTR_W'(1 << STALL_WATERMARK);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Storage and pointers; the pointer MSB is the wrap bit.
  logic [WORD_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      n_wr_ptr;
  logic [PTR_W-1:0]      n_rd_ptr;
  logic [PTR_W-1:0]      n_count;

  // FSM
  state_t                state;
  state_t                n_state;
  logic [BEAT_W-1:0]     beat;
  logic [BEAT_W-1:0]     n_beat;

  // Next values of the registered beat outputs
  logic [DATA_WIDTH-1:0] n_bk_data;
  logic                  n_bk_valid;
  logic                  n_bk_last;

  logic                  wr_req;
  logic                  pop;
  logic                  proto_hit;

  logic [WORD_W-1:0]     rd_word;
  logic [DATA_WIDTH-1:0] rd_beats [BEATS];

  // Fullness is judged on the registered flag, so a push in the pop cycle
  // of a full FIFO is still dropped.
  assign wr_req = wr_en && !o_full;

  assign rd_word = mem[rd_ptr[FIFO_DEPTH-1:0]];

  for (genvar k = 0; k < BEATS; k++) begin : g_beat_split
    assign rd_beats[k] = rd_word[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, so clearing the contents would buy nothing.
  always_ff @(posedge i_clk) begin
    if (wr_req) begin
      mem[wr_ptr[FIFO_DEPTH-1:0]] <= i_data;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and next-output logic
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    n_state    = state;
    n_beat     = beat;
    n_bk_data  = o_bk_data;
    n_bk_valid = 1'b0;
    n_bk_last  = 1'b0;
    pop        = 1'b0;
    proto_hit  = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_burst_req) begin
          if (o_empty) begin
            proto_hit = 1'b1;
          end else begin
            // Beat 0 is registered at the accepting edge so it appears in
            // the first cycle after the request.
            n_state    = SEND;
            n_beat     = '0;
            n_bk_data  = rd_beats[0];
            n_bk_valid = 1'b1;
            n_bk_last  = (LAST_BEAT == '0);
          end
        end
      end

      SEND: begin
        // `beat` is the index currently on o_bk_data.
        proto_hit = i_burst_req;
        if (beat == LAST_BEAT) begin
          pop     = 1'b1;
          n_state = IDLE;
          n_beat  = '0;
        end else begin
          n_beat     = beat + 1'b1;
          n_bk_data  = rd_beats[n_beat];
          n_bk_valid = 1'b1;
          n_bk_last  = (n_beat == LAST_BEAT);
        end
      end

      default: begin
        n_state = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= n_state;
      beat  <= n_beat;
    end
  end

  // ---------------------------------------------------------------------
  // Pointers and status, registered from next-state pointers
  // ---------------------------------------------------------------------
  assign n_wr_ptr = wr_ptr + PTR_W'(wr_req);
  assign n_rd_ptr = rd_ptr + PTR_W'(pop);
  assign n_count  = n_wr_ptr - n_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
      o_stall <= 1'b0;
      o_count <= '0;
    end else begin
      wr_ptr  <= n_wr_ptr;
      rd_ptr  <= n_rd_ptr;
      o_full  <= (n_wr_ptr[FIFO_DEPTH] != n_rd_ptr[FIFO_DEPTH]) &&
                 (n_wr_ptr[FIFO_DEPTH-1:0] == n_rd_ptr[FIFO_DEPTH-1:0]);
      o_empty <= (n_wr_ptr == n_rd_ptr);
      o_stall <= (n_count >= STALL_COUNT);
      o_count <= n_count;
    end
  end

  // ---------------------------------------------------------------------
  // Backend beat outputs and protocol error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bk_data   <= '0;
      o_bk_valid  <= 1'b0;
      o_bk_last   <= 1'b0;
      o_busy      <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      o_bk_data   <= n_bk_data;
      o_bk_valid  <= n_bk_valid;
      o_bk_last   <= n_bk_last;
      o_busy      <= (n_state == SEND);
      o_proto_err <= o_proto_err || proto_hit;
    end
  end

endmodule

// File: tb/tb_write_data_dispatch.sv
// Directed bench for write_data_dispatch with DATA_WIDTH=32, BEATS=2,
// FIFO_DEPTH=2, STALL_WATERMARK=1. A queue holds the words the bench
// expects the FIFO to contain; each burst pops the front word and compares
// its beats against the DUT output.

module tb_write_data_dispatch;

  localparam int DW     = 32;
  localparam int BEATS  = 2;
  localparam int FD     = 2;
  localparam int SW     = 1;
  localparam int DEPTH  = 1 << FD;
  localparam int WORD_W = BEATS * DW;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [WORD_W-1:0] i_data;
  logic              wr_en;
  logic              o_full;
  logic              o_empty;
  logic              o_stall;
  logic [FD:0]       o_count;
  logic              i_burst_req;
  logic [DW-1:0]     o_bk_data;
  logic              o_bk_valid;
  logic              o_bk_last;
  logic              o_busy;
  logic              o_proto_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [WORD_W-1:0] model_q [$];

  write_data_dispatch #(
    .DATA_WIDTH      (DW),
    .BEATS           (BEATS),
    .FIFO_DEPTH      (FD),
    .STALL_WATERMARK (SW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .wr_en       (wr_en),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_stall     (o_stall),
    .o_count     (o_count),
    .i_burst_req (i_burst_req),
    .o_bk_data   (o_bk_data),
    .o_bk_valid  (o_bk_valid),
    .o_bk_last   (o_bk_last),
    .o_busy      (o_busy),
    .o_proto_err (o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = model_q.size();
    check({tag, " count"}, 64'(o_count), 64'(n));
    check({tag, " empty"}, 64'(o_empty), 64'(n == 0));
    check({tag, " full"},  64'(o_full),  64'(n == DEPTH));
    check({tag, " stall"}, 64'(o_stall), 64'(n >= (1 << SW)));
  endtask

  task automatic push(input logic [WORD_W-1:0] word, input string tag);
    wr_en  = 1'b1;
    i_data = word;
    tick();
    wr_en  = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(word);
    check_status(tag);
  endtask

  // One legal burst. Optionally pushes a word during the last-beat cycle
  // and/or raises a second request during the first beat.
  task automatic burst(input string tag, input bit push_last,
                       input logic [WORD_W-1:0] push_word, input bit req_again);
    logic [WORD_W-1:0] w;
    bit                full_before;
    full_before = (model_q.size() == DEPTH);
    w = model_q.pop_front();
    i_burst_req = 1'b1;
    tick();
    i_burst_req = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      check({tag, " valid"}, 64'(o_bk_valid), 64'd1);
      check({tag, " busy"},  64'(o_busy),     64'd1);
      check({tag, " last"},  64'(o_bk_last),  64'(k == BEATS - 1));
      check({tag, " data"},  64'(o_bk_data),  64'(w[k*DW +: DW]));
      if (req_again && k == 0) i_burst_req = 1'b1;
      if (push_last && k == BEATS - 1) begin
        wr_en  = 1'b1;
        i_data = push_word;
      end
      tick();
      i_burst_req = 1'b0;
      wr_en       = 1'b0;
    end
    if (push_last && !full_before) model_q.push_back(push_word);
    check({tag, " end valid"}, 64'(o_bk_valid), 64'd0);
    check({tag, " end busy"},  64'(o_busy),     64'd0);
    check({tag, " end last"},  64'(o_bk_last),  64'd0);
    check_status({tag, " end"});
  endtask

  initial begin
    i_rst       = 1'b1;
    i_data      = '0;
    wr_en       = 1'b0;
    i_burst_req = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst empty", 64'(o_empty),     64'd1);
    check("rst full",  64'(o_full),      64'd0);
    check("rst stall", 64'(o_stall),     64'd0);
    check("rst count", 64'(o_count),     64'd0);
    check("rst valid", 64'(o_bk_valid),  64'd0);
    check("rst last",  64'(o_bk_last),   64'd0);
    check("rst data",  64'(o_bk_data),   64'd0);
    check("rst busy",  64'(o_busy),      64'd0);
    check("rst perr",  64'(o_proto_err), 64'd0);
    i_rst = 1'b0;
    tick();

    // Single word round trip
    push(64'h2222_2222_1111_1111, "t1 push");
    burst("t1 burst", 1'b0, '0, 1'b0);

    // Five back-to-back pushes, fifth dropped, then drain in order
    for (int i = 1; i <= 5; i++) begin
      push({32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, $sformatf("t2 push%0d", i));
    end
    for (int i = 1; i <= 4; i++) begin
      burst($sformatf("t2 burst%0d", i), 1'b0, '0, 1'b0);
    end

    // Push/burst pairs across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      push({32'hC0DE_0000 + 32'(i), 32'hFACE_0000 + 32'(i)}, $sformatf("t3 push%0d", i));
      burst($sformatf("t3 burst%0d", i), 1'b0, '0, 1'b0);
    end

    // Full FIFO: push in the last-beat cycle is dropped
    for (int i = 0; i < DEPTH; i++) begin
      push({32'hD100_0000 + 32'(i), 32'hD200_0000 + 32'(i)}, $sformatf("t4 fill%0d", i));
    end
    burst("t4 full pop", 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
    // Not full: push and pop in the same cycle both take effect
    burst("t4 pushpop", 1'b1, 64'h7777_7777_6666_6666, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      burst($sformatf("t4 drain%0d", i), 1'b0, '0, 1'b0);
    end

    // Illegal requests: while empty, then during SEND
    i_burst_req = 1'b1;
    tick();
    i_burst_req = 1'b0;
    check("t5 empty req valid", 64'(o_bk_valid),  64'd0);
    check("t5 empty req busy",  64'(o_busy),      64'd0);
    check("t5 empty req perr",  64'(o_proto_err), 64'd1);
    tick();
    check("t5 no beat", 64'(o_bk_valid), 64'd0);
    push(64'h4444_4444_3333_3333, "t5 push");
    burst("t5 dbl req", 1'b0, '0, 1'b1);
    tick();
    check("t5 no extra valid", 64'(o_bk_valid),  64'd0);
    check("t5 no extra busy",  64'(o_busy),      64'd0);
    check("t5 perr sticky",    64'(o_proto_err), 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t5 perr cleared", 64'(o_proto_err), 64'd0);
    model_q.delete();

    // Reset during beat 0
    push(64'h9999_9999_8888_8888, "t6 push0");
    push(64'hBBBB_BBBB_AAAA_AAAA, "t6 push1");
    i_burst_req = 1'b1;
    tick();
    i_burst_req = 1'b0;
    check("t6 beat0 valid", 64'(o_bk_valid), 64'd1);
    check("t6 beat0 data",  64'(o_bk_data),  64'h8888_8888);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_q.delete();
    check("t6 valid", 64'(o_bk_valid), 64'd0);
    check("t6 busy",  64'(o_busy),     64'd0);
    check("t6 last",  64'(o_bk_last),  64'd0);
    check_status("t6 after rst");
    tick();
    check("t6 idle valid", 64'(o_bk_valid), 64'd0);
    push(64'hEEEE_EEEE_CCCC_CCCC, "t6 recover push");
    burst("t6 recover", 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
